serial_add_ctrl: RTL and testbench

//   Bit-serial N-bit adder controller that sequences one external 1-bit full adder (fa).

---
 rtl/serial_add_ctrl.sv | 95 +++++++++
 tb/tb_serial_add_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder controller: sequences one external 1-bit full adder,
// LSB first, and presents the registered sum and carry-out with a one-cycle done pulse.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_next;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Shift form rather than a part-select so WIDTH=1 stays legal.
  always_comb begin
    s_next = (s_sh >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
  end

  // The fa sees operand bits only in RUN; gating on state keeps it quiet in IDLE/DONE and in reset.
  assign fa_a   = (state == RUN) & a_sh[0];
  assign fa_b   = (state == RUN) & b_sh[0];
  assign fa_cin = (state == RUN) & carry;

  // NOTE: every register here is sequential state, so all updates use <= to avoid
  // ordering races between the shift registers and the counter compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      s_sh     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum_out  <= '0;
      cout_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_in;
            carry <= cin_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          s_sh  <= s_next;
          carry <= fa_cout;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            sum_out  <= s_next;
            cout_out <= fa_cout;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl (WIDTH=8) with a behavioural full adder on the fa_* ports.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       cin_in;
  logic       busy;
  logic       done;
  logic [7:0] sum_out;
  logic       cout_out;
  logic       fa_a;
  logic       fa_b;
  logic       fa_cin;
  logic       fa_sum;
  logic       fa_cout;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int n_ops = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
    .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check("result", {23'd0, cout_out, sum_out}, {23'd0, e});
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  // chaos keeps start high and scrambles the operand inputs while the op is in flight.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c, input bit chaos);
    logic [8:0] exp;
    logic [7:0] seq_a;
    logic [7:0] seq_b;
    logic       first_cin;
    int         bc;
    start  = 1'b1;
    a_in   = a;
    b_in   = b;
    cin_in = c;
    exp = {1'b0, a} + {1'b0, b} + {8'd0, c};
    @(posedge clk);
    exp_q.push_back(exp);
    n_ops++;
    #1;
    if (!chaos) start = 1'b0;
    bc = 0;
    seq_a = '0;
    seq_b = '0;
    first_cin = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) bc++;
      seq_a[i] = fa_a;
      seq_b[i] = fa_b;
      if (i == 0) first_cin = fa_cin;
      if (chaos) begin
        a_in   = 8'($urandom);
        b_in   = 8'($urandom);
        cin_in = 1'($urandom);
      end
    end
    check("busy_cycles", bc, 8);
    check("fa_a_seq", {24'd0, seq_a}, {24'd0, a});
    check("fa_b_seq", {24'd0, seq_b}, {24'd0, b});
    check("fa_cin_first", {31'd0, first_cin}, {31'd0, c});
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd1);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    check("fa_zero_in_done", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    @(negedge clk);
    check("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b1;
    a_in   = 8'h5A;
    b_in   = 8'hA5;
    cin_in = 1'b1;
    @(negedge clk);
    check("reset_busy_done", {30'd0, busy, done}, 32'd0);
    check("reset_result", {23'd0, cout_out, sum_out}, 32'd0);
    check("reset_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {30'd0, busy, done}, 32'd0);

    run_op(8'h03, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    run_op(8'h3C, 8'h44, 1'b1, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b1);

    // Reset in the fourth RUN cycle: result discarded, no done.
    run_op(8'h7F, 8'h01, 1'b0, 1'b0);
    start  = 1'b1;
    a_in   = 8'h55;
    b_in   = 8'h66;
    cin_in = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrun_rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("midrun_rst_result", {23'd0, cout_out, sum_out}, 32'd0);
    check("midrun_rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_done_after_rst", {31'd0, done}, 32'd0);
    check("result_held_zero", {23'd0, cout_out, sum_out}, 32'd0);
    run_op(8'h10, 8'h20, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    check("done_count", done_cnt, n_ops);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
